// File: rtl/spi_controller.sv
// Write-only SPI (mode 0) controller: sends one 16-bit frame {1, addr[6:0], data[7:0]} per accepted start.
// Optional address range check is compiled in with SPI_CONTROLLER_ADDR_CHECK_EN.
module spi_controller #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       SCLK,
  output logic       COPI,
  output logic       nCS
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [4:0]  bit_reg, bit_next;
  logic [15:0] frame_reg, frame_next;
  logic        sclk_reg, sclk_next;
  logic        copi_reg, copi_next;
  logic        ncs_reg, ncs_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;
  logic        addr_bad;

`ifdef SPI_CONTROLLER_ADDR_CHECK_EN
  assign addr_bad = (wr_addr > 7'h04);
`else
  assign addr_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      frame_reg <= '0;
      sclk_reg  <= 1'b0;
      copi_reg  <= 1'b0;
      ncs_reg   <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      frame_reg <= frame_next;
      sclk_reg  <= sclk_next;
      copi_reg  <= copi_next;
      ncs_reg   <= ncs_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    frame_next = frame_reg;
    sclk_next  = sclk_reg;
    copi_next  = copi_reg;
    ncs_next   = ncs_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          if (addr_bad) begin
            err_next = 1'b1;
          end else begin
            state_next = SETUP;
            frame_next = {1'b1, wr_addr, wr_data};
            cnt_next   = '0;
            bit_next   = '0;
            ncs_next   = 1'b0;
            sclk_next  = 1'b0;
            copi_next  = 1'b1;
            busy_next  = 1'b1;
          end
        end
      end
      SETUP: begin
        if (cnt_reg == DIV_LAST) begin
          state_next = SHIFT;
          cnt_next   = '0;
          sclk_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      SHIFT: begin
        if (cnt_reg == DIV_LAST) begin
          cnt_next = '0;
          if (sclk_reg) begin
            // Falling edge: bit_reg counts completed periods; present the next bit.
            sclk_next = 1'b0;
            bit_next  = bit_reg + 5'd1;
            if (bit_reg != 5'd15)
              copi_next = frame_reg[4'd14 - bit_reg[3:0]];
          end else if (bit_reg == 5'd16) begin
            state_next = HOLD;
          end else begin
            sclk_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      HOLD: begin
        if (cnt_reg == DIV_LAST) begin
          state_next = GAP;
          cnt_next   = '0;
          ncs_next   = 1'b1;
          copi_next  = 1'b0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      GAP: begin
        if (cnt_reg == GAP_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign err  = err_reg;
  assign SCLK = sclk_reg;
  assign COPI = copi_reg;
  assign nCS  = ncs_reg;

endmodule

// File: tb/tb_spi_controller.sv
// Randomized bench for spi_controller: two instances (CLK_DIV=4/CS_GAP=2 and CLK_DIV=1/CS_GAP=3)
// checked against frame contents and cycle timing computed from the protocol rules.
module tb_spi_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, sel;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       start0, start1;
  logic       busy0, done0, err0, sclk0, copi0, ncs0;
  logic       busy1, done1, err1, sclk1, copi1, ncs1;
  logic       busy, done, err, sclk, copi, ncs;

  assign start0 = start & ~sel;
  assign start1 = start & sel;

  spi_controller #(.CLK_DIV(4), .CS_GAP(2)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy0), .done(done0), .err(err0), .SCLK(sclk0), .COPI(copi0), .nCS(ncs0)
  );

  spi_controller #(.CLK_DIV(1), .CS_GAP(3)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy1), .done(done1), .err(err1), .SCLK(sclk1), .COPI(copi1), .nCS(ncs1)
  );

  assign busy = sel ? busy1 : busy0;
  assign done = sel ? done1 : done0;
  assign err  = sel ? err1  : err0;
  assign sclk = sel ? sclk1 : sclk0;
  assign copi = sel ? copi1 : copi0;
  assign ncs  = sel ? ncs1  : ncs0;

`ifdef SPI_CONTROLLER_ADDR_CHECK_EN
  localparam int ADDR_MAX = 4;
`else
  localparam int ADDR_MAX = 127;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cd, gap;

  // Per-frame observations, measured in cycles after the accepting edge (cycle 1 = first cycle after it).
  logic [15:0] r_bits;
  int r_nbits, r_ncs_first, r_ncs_last, r_ncs_falls, r_done_cyc, r_done_cnt;
  int r_busy_cnt, r_busy_at_done, r_err_cyc, r_err_cnt, r_sclk_hi, r_rst_ok;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called right after a negedge: raises start for cycle 0, then watches up to max_cyc cycles.
  task automatic run_frame(input logic [6:0] addr, input logic [7:0] data, input int max_cyc,
                           input bit stop_on_done, input int drop_cyc, input int chg_cyc,
                           input logic [7:0] chg_data, input int rst_cyc);
    logic prev_ncs, prev_sclk;
    r_bits = '0; r_nbits = 0; r_ncs_first = 0; r_ncs_last = 0; r_ncs_falls = 0;
    r_done_cyc = 0; r_done_cnt = 0; r_busy_cnt = 0; r_busy_at_done = -1;
    r_err_cyc = 0; r_err_cnt = 0; r_sclk_hi = 0; r_rst_ok = -1;
    prev_ncs = 1'b1; prev_sclk = 1'b0;
    wr_addr = addr; wr_data = data; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (c >= drop_cyc) start = 1'b0;
      if (!ncs) begin
        if (r_ncs_first == 0) r_ncs_first = c;
        r_ncs_last = c;
      end
      if (prev_ncs && !ncs) r_ncs_falls++;
      if (!prev_sclk && sclk) begin
        r_bits = {r_bits[14:0], copi};
        r_nbits++;
      end
      if (sclk) r_sclk_hi++;
      if (busy) r_busy_cnt++;
      if (err) begin
        if (r_err_cyc == 0) r_err_cyc = c;
        r_err_cnt++;
      end
      if (c == rst_cyc + 1) r_rst_ok = (ncs && !sclk && !busy) ? 1 : 0;
      rst = (c == rst_cyc);
      if (c == chg_cyc) wr_data = chg_data;
      prev_ncs = ncs; prev_sclk = sclk;
      if (done) begin
        r_done_cnt++;
        if (r_done_cyc == 0) begin
          r_done_cyc = c;
          r_busy_at_done = busy;
        end
        if (stop_on_done) break;
      end
    end
  endtask

  // Expected values come from the protocol timing: nCS low for 34*cd cycles starting at cycle 1,
  // then gap cycles with nCS high, done in the cycle after that.
  task automatic check_frame(input string tag, input logic [6:0] addr, input logic [7:0] data);
    int exp_done;
    exp_done = 34 * cd + gap + 1;
    check({tag, ".bits"},      r_bits, {1'b1, addr, data});
    check({tag, ".nbits"},     r_nbits, 16);
    check({tag, ".ncs_first"}, r_ncs_first, 1);
    check({tag, ".ncs_last"},  r_ncs_last, 34 * cd);
    check({tag, ".ncs_falls"}, r_ncs_falls, 1);
    check({tag, ".done_cyc"},  r_done_cyc, exp_done);
    check({tag, ".done_cnt"},  r_done_cnt, 1);
    check({tag, ".busy_cnt"},  r_busy_cnt, exp_done - 1);
    check({tag, ".busy_done"}, r_busy_at_done, 0);
    check({tag, ".sclk_hi"},   r_sclk_hi, 16 * cd);
    check({tag, ".err_cnt"},   r_err_cnt, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [6:0] a, a2;
    logic [7:0] d, d2;
    sel = 1'b0; rst = 1'b1; start = 1'b0; wr_addr = '0; wr_data = '0;
    cd = 4; gap = 2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.ncs", ncs, 1);
    check("rst.sclk", sclk, 0);
    check("rst.copi", copi, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.err", err, 0);
    rst = 1'b0;
    idle(1);

    run_frame(7'h02, 8'hA5, 200, 1, 1, 0, 8'h00, 0);
    check_frame("single", 7'h02, 8'hA5);
    idle(2);

    for (int i = 0; i < 5; i++) begin
      a = 7'($urandom_range(0, ADDR_MAX)); d = 8'($urandom);
      run_frame(a, d, 200, 1, 1, 0, 8'h00, 0);
      check_frame($sformatf("rand%0d", i), a, d);
      idle(int'($urandom_range(0, 3)));
    end

    a = 7'($urandom_range(0, ADDR_MAX)); d = 8'($urandom);
    a2 = 7'($urandom_range(0, ADDR_MAX)); d2 = 8'($urandom);
    run_frame(a, d, 200, 1, 1, 0, 8'h00, 0);
    check_frame("b2b1", a, d);
    check("b2b.gap_hi", r_done_cyc - r_ncs_last - 1, gap);
    run_frame(a2, d2, 200, 1, 1, 0, 8'h00, 0);
    check_frame("b2b2", a2, d2);
    idle(2);

    a = 7'($urandom_range(0, ADDR_MAX)); d = 8'($urandom);
    d2 = ~d;
    run_frame(a, d, 34 * cd + gap + 30, 0, 100, 40, d2, 0);
    check_frame("hold", a, d);
    idle(2);

    a = 7'($urandom_range(0, ADDR_MAX)); d = 8'($urandom);
    run_frame(a, d, 200, 0, 1, 0, 8'h00, 60);
    check("rst_mid.state", r_rst_ok, 1);
    check("rst_mid.done_cnt", r_done_cnt, 0);
    idle(2);
    a = 7'($urandom_range(0, ADDR_MAX)); d = 8'($urandom);
    run_frame(a, d, 200, 1, 1, 0, 8'h00, 0);
    check_frame("after_rst", a, d);
    idle(2);

    d = 8'($urandom);
`ifdef SPI_CONTROLLER_ADDR_CHECK_EN
    run_frame(7'h05, d, 10, 0, 1, 0, 8'h00, 0);
    check("badaddr.err_cyc", r_err_cyc, 1);
    check("badaddr.err_cnt", r_err_cnt, 1);
    check("badaddr.ncs_falls", r_ncs_falls, 0);
    check("badaddr.busy_cnt", r_busy_cnt, 0);
    idle(1);
    run_frame(7'h04, d, 200, 1, 1, 0, 8'h00, 0);
    check_frame("addr4", 7'h04, d);
`else
    run_frame(7'h05, d, 200, 1, 1, 0, 8'h00, 0);
    check_frame("addr5", 7'h05, d);
`endif
    idle(2);

    sel = 1'b1; cd = 1; gap = 3;
    idle(1);
    for (int i = 0; i < 4; i++) begin
      a = 7'($urandom_range(0, ADDR_MAX)); d = 8'($urandom);
      run_frame(a, d, 100, 1, 1, 0, 8'h00, 0);
      check_frame($sformatf("div1_%0d", i), a, d);
      idle(int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
